// File: rtl/fsk_uart_tx_if.sv
// Byte handshake and serial-side status between a byte source and fsk_uart_tx.
//   tx_data    : byte to frame, sampled on accept (master -> slave)
//   tx_valid   : tx_data valid (master -> slave)
//   tx_ready   : framer can accept; accept = tx_valid & tx_ready (slave -> master)
//   tx_bit     : registered serial line to the 2FSK modulator, idle/mark = 1
//   tx_busy    : frame in progress
//   frame_done : 1-cycle pulse in the last cycle of the final stop bit
interface fsk_uart_tx_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_bit;
  logic                 tx_busy;
  logic                 frame_done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_bit,
    input  tx_busy,
    input  frame_done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_bit,
    output tx_busy,
    output frame_done
  );
endinterface

// File: rtl/fsk_uart_tx.sv
// UART-style framer feeding the 2FSK modulator's serial input.
// Frames each accepted byte as start(0), data LSB-first, optional even parity,
// and STOP_BITS stop bits(1), each symbol held CLKS_PER_BIT sample clocks.
// Ports:
//   clk_sample : sampling clock (only clock)
//   rst        : synchronous reset, active-high
//   bus        : fsk_uart_tx_if slave (tx_data/tx_valid/tx_ready handshake,
//                tx_bit, tx_busy, frame_done), all outputs registered
module fsk_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 64,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic          clk_sample,
  input  logic          rst,
  fsk_uart_tx_if.slave  bus
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 parity_q;
  logic                 tx_bit_q;
  logic                 tx_ready_q;
  logic                 tx_busy_q;
  logic                 frame_done_q;

  logic accept;
  logic bit_end;

  // tx_ready_q is only high in IDLE and in the last stop cycle, so accept
  // covers both the idle start and the gapless back-to-back start.
  assign accept  = bus.tx_valid & tx_ready_q;
  assign bit_end = (cnt_q == CNT_LAST);

  assign bus.tx_bit     = tx_bit_q;
  assign bus.tx_ready   = tx_ready_q;
  assign bus.tx_busy    = tx_busy_q;
  assign bus.frame_done = frame_done_q;

  // Framer FSM; outputs are computed for the cycle following each edge.
  always_ff @(posedge clk_sample) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shreg_q      <= '0;
      parity_q     <= 1'b0;
      tx_bit_q     <= 1'b1;
      tx_ready_q   <= 1'b0;
      tx_busy_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (accept) begin
        shreg_q    <= bus.tx_data;
        parity_q   <= ^bus.tx_data;
        state_q    <= S_START;
        cnt_q      <= '0;
        idx_q      <= '0;
        tx_bit_q   <= 1'b0;
        tx_ready_q <= 1'b0;
        tx_busy_q  <= 1'b1;
      end else begin
        cnt_q <= bit_end ? '0 : cnt_q + CNT_W'(1);
        case (state_q)
          S_IDLE: begin
            cnt_q      <= '0;
            idx_q      <= '0;
            tx_bit_q   <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
          end

          S_START: begin
            if (bit_end) begin
              state_q  <= S_DATA;
              idx_q    <= '0;
              tx_bit_q <= shreg_q[0];
            end
          end

          S_DATA: begin
            if (bit_end) begin
              shreg_q <= shreg_q >> 1;
              if (idx_q == DATA_LAST) begin
                idx_q <= '0;
                if (PARITY_EN != 0) begin
                  state_q  <= S_PARITY;
                  tx_bit_q <= parity_q;
                end else begin
                  state_q  <= S_STOP;
                  tx_bit_q <= 1'b1;
                end
              end else begin
                idx_q    <= idx_q + IDX_W'(1);
                tx_bit_q <= shreg_q[1];
              end
            end
          end

          S_PARITY: begin
            if (bit_end) begin
              state_q  <= S_STOP;
              idx_q    <= '0;
              tx_bit_q <= 1'b1;
            end
          end

          S_STOP: begin
            // idx_q counts stop bits; done/ready are raised one cycle early
            // so that the registered outputs land in the final cycle.
            if (bit_end) begin
              if (idx_q == STOP_LAST) begin
                state_q   <= S_IDLE;
                idx_q     <= '0;
                tx_busy_q <= 1'b0;
              end else begin
                idx_q <= idx_q + IDX_W'(1);
              end
            end else if ((idx_q == STOP_LAST) && (cnt_q == CNT_PRE)) begin
              frame_done_q <= 1'b1;
              tx_ready_q   <= 1'b1;
            end
          end

          default: begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            tx_bit_q   <= 1'b1;
            tx_ready_q <= 1'b0;
            tx_busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fsk_uart_tx.sv
// Directed bench for fsk_uart_tx: three instances (CLKS_PER_BIT=4 basic,
// CLKS_PER_BIT=4 with even parity and two stop bits, default 64-clock symbols).
module tb_fsk_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  int   errors = 0;
  int   checks = 0;

  fsk_uart_tx_if #(.DATA_BITS(8)) bus_a ();
  fsk_uart_tx_if #(.DATA_BITS(8)) bus_b ();
  fsk_uart_tx_if #(.DATA_BITS(8)) bus_c ();

  fsk_uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(1))
    u_a (.clk_sample(clk), .rst(rst_a), .bus(bus_a));
  fsk_uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(2))
    u_b (.clk_sample(clk), .rst(rst_b), .bus(bus_b));
  fsk_uart_tx #(.CLKS_PER_BIT(64), .DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(1))
    u_c (.clk_sample(clk), .rst(rst_c), .bus(bus_c));

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level for symbol s of a frame (0 = start, 1..8 data, then parity/stop).
  function automatic logic exp_sym(input logic [7:0] d, input int s, input int par_en);
    if (s == 0) return 1'b0;
    if (s <= 8) return d[3'(s - 1)];
    if (par_en != 0 && s == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic test_reset();
    logic [3:0] got;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    bus_a.tx_valid = 1'b0; bus_b.tx_valid = 1'b0; bus_c.tx_valid = 1'b0;
    bus_a.tx_data = 8'h00; bus_b.tx_data = 8'h00; bus_c.tx_data = 8'h00;
    repeat (3) tick();
    got = {bus_a.tx_bit, bus_a.tx_ready, bus_a.tx_busy, bus_a.frame_done};
    checks++; if (got !== 4'b1000) begin errors++; $display("FAIL reset_a: bit/ready/busy/done=%b expected 1000", got); end
    got = {bus_b.tx_bit, bus_b.tx_ready, bus_b.tx_busy, bus_b.frame_done};
    checks++; if (got !== 4'b1000) begin errors++; $display("FAIL reset_b: bit/ready/busy/done=%b expected 1000", got); end
    got = {bus_c.tx_bit, bus_c.tx_ready, bus_c.tx_busy, bus_c.frame_done};
    checks++; if (got !== 4'b1000) begin errors++; $display("FAIL reset_c: bit/ready/busy/done=%b expected 1000", got); end
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    tick();
    got = {bus_a.tx_ready, bus_b.tx_ready, bus_c.tx_ready, bus_a.tx_bit};
    checks++; if (got !== 4'b1111) begin errors++; $display("FAIL idle_ready: ready_a/b/c,bit_a=%b expected 1111", got); end
  endtask

  task automatic test_frame_a5();
    logic [3:0] got, exp;
    bus_a.tx_data = 8'hA5; bus_a.tx_valid = 1'b1;
    tick();
    bus_a.tx_valid = 1'b0; bus_a.tx_data = 8'h00;
    for (int c = 1; c <= 41; c++) begin
      got = {bus_a.tx_bit, bus_a.tx_busy, bus_a.frame_done, bus_a.tx_ready};
      if (c <= 40) exp = {exp_sym(8'hA5, (c - 1) / 4, 0), 1'b1, c == 40, c == 40};
      else         exp = 4'b1001;
      checks++;
      if (got !== exp) begin errors++; $display("FAIL frame_a5 cycle %0d: bit/busy/done/ready=%b expected %b", c, got, exp); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] got, exp;
    int dones = 0;
    int pos;
    bus_a.tx_data = 8'h00; bus_a.tx_valid = 1'b1;
    tick();
    bus_a.tx_data = 8'hFF;
    for (int c = 1; c <= 85; c++) begin
      if (c == 41) bus_a.tx_valid = 1'b0;
      got = {bus_a.tx_bit, bus_a.tx_busy, bus_a.frame_done, bus_a.tx_ready};
      if (bus_a.frame_done === 1'b1) dones++;
      pos = (c - 1) % 40;
      if (c <= 80) exp = {exp_sym((c > 40) ? 8'hFF : 8'h00, pos / 4, 0), 1'b1, pos == 39, pos == 39};
      else         exp = 4'b1001;
      checks++;
      if (got !== exp) begin errors++; $display("FAIL back_to_back cycle %0d: bit/busy/done/ready=%b expected %b", c, got, exp); end
      tick();
    end
    checks++;
    if (dones != 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", dones); end
  endtask

  task automatic test_parity_stop2();
    logic [3:0] got, exp;
    bus_b.tx_data = 8'h07; bus_b.tx_valid = 1'b1;
    tick();
    bus_b.tx_valid = 1'b0;
    for (int c = 1; c <= 49; c++) begin
      got = {bus_b.tx_bit, bus_b.tx_busy, bus_b.frame_done, bus_b.tx_ready};
      if (c <= 48) exp = {exp_sym(8'h07, (c - 1) / 4, 1), 1'b1, c == 48, c == 48};
      else         exp = 4'b1001;
      checks++;
      if (got !== exp) begin errors++; $display("FAIL parity_stop2 cycle %0d: bit/busy/done/ready=%b expected %b", c, got, exp); end
      tick();
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] got;
    int dones = 0;
    int high_errs = 0;
    bus_a.tx_data = 8'hA5; bus_a.tx_valid = 1'b1;
    tick();
    bus_a.tx_valid = 1'b0;
    repeat (17) tick();
    got = {bus_a.tx_bit, bus_a.tx_busy, bus_a.frame_done, bus_a.tx_ready};
    checks++; if (got !== 4'b0100) begin errors++; $display("FAIL mid_data3: bit/busy/done/ready=%b expected 0100", got); end
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    got = {bus_a.tx_bit, bus_a.tx_busy, bus_a.frame_done, bus_a.tx_ready};
    checks++; if (got !== 4'b1000) begin errors++; $display("FAIL after_rst: bit/busy/done/ready=%b expected 1000", got); end
    for (int c = 0; c < 60; c++) begin
      tick();
      if (bus_a.frame_done === 1'b1) dones++;
      if (bus_a.tx_bit !== 1'b1) high_errs++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL rst_no_done: got %0d pulses expected 0", dones); end
    checks++; if (high_errs != 0) begin errors++; $display("FAIL rst_line_idle: got %0d low cycles expected 0", high_errs); end
    checks++; if (bus_a.tx_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", bus_a.tx_ready); end
    bus_a.tx_data = 8'h96; bus_a.tx_valid = 1'b1;
    tick();
    bus_a.tx_valid = 1'b0;
    for (int c = 1; c <= 41; c++) begin
      if ((c - 1) % 4 == 1 && c < 40) begin
        checks++;
        if (bus_a.tx_bit !== exp_sym(8'h96, (c - 1) / 4, 0)) begin
          errors++; $display("FAIL post_rst_frame sym %0d: got %b expected %b", (c - 1) / 4, bus_a.tx_bit, exp_sym(8'h96, (c - 1) / 4, 0));
        end
      end
      if (c == 40) begin
        checks++;
        if (bus_a.frame_done !== 1'b1) begin errors++; $display("FAIL post_rst_done: got %b expected 1", bus_a.frame_done); end
      end
      tick();
    end
  endtask

  task automatic test_ignore_busy();
    logic [3:0] got, exp;
    bus_a.tx_data = 8'h81; bus_a.tx_valid = 1'b1;
    tick();
    bus_a.tx_valid = 1'b0;
    for (int c = 1; c <= 41; c++) begin
      bus_a.tx_valid = (c == 10 || c == 22 || (c >= 30 && c <= 35));
      bus_a.tx_data  = bus_a.tx_valid ? 8'h3C : 8'h00;
      got = {bus_a.tx_bit, bus_a.tx_busy, bus_a.frame_done, bus_a.tx_ready};
      if (c <= 40) exp = {exp_sym(8'h81, (c - 1) / 4, 0), 1'b1, c == 40, c == 40};
      else         exp = 4'b1001;
      checks++;
      if (got !== exp) begin errors++; $display("FAIL ignore_busy cycle %0d: bit/busy/done/ready=%b expected %b", c, got, exp); end
      tick();
    end
    bus_a.tx_valid = 1'b0;
  endtask

  // Reference receiver: detect start edge, sample at each symbol centre,
  // and time every line transition in sample clocks (64 clocks = 1 us at 64 MHz).
  task automatic test_default_rx();
    int   fall = -1;
    int   done_cyc = -1;
    int   k = 0;
    int   ntr = 0;
    int   tr[12];
    logic samp[10];
    logic prev = 1'b1;
    logic [7:0] rx_byte;
    bus_c.tx_data = 8'h55; bus_c.tx_valid = 1'b1;
    tick();
    bus_c.tx_valid = 1'b0;
    for (int c = 1; c <= 700; c++) begin
      if (fall < 0 && bus_c.tx_bit === 1'b0) fall = c;
      if (bus_c.tx_bit !== prev) begin
        if (ntr < 12) tr[ntr] = c;
        ntr++;
        prev = bus_c.tx_bit;
      end
      if (fall >= 0 && k < 10 && (c - fall) == 32 + 64 * k) begin
        samp[k] = bus_c.tx_bit;
        k++;
      end
      if (done_cyc < 0 && bus_c.frame_done === 1'b1) done_cyc = c;
      tick();
    end
    for (int i = 0; i < 8; i++) rx_byte[i] = samp[i + 1];
    checks++; if (fall != 1) begin errors++; $display("FAIL rx_start_latency: got %0d expected 1", fall); end
    checks++; if (k != 10) begin errors++; $display("FAIL rx_samples: got %0d expected 10", k); end
    checks++; if (samp[0] !== 1'b0) begin errors++; $display("FAIL rx_start_bit: got %b expected 0", samp[0]); end
    checks++; if (rx_byte !== 8'h55) begin errors++; $display("FAIL rx_byte: got %h expected 55", rx_byte); end
    checks++; if (samp[9] !== 1'b1) begin errors++; $display("FAIL rx_stop_bit: got %b expected 1", samp[9]); end
    checks++; if (ntr != 10) begin errors++; $display("FAIL rx_transitions: got %0d expected 10", ntr); end
    for (int i = 1; i < 10 && i < ntr; i++) begin
      checks++;
      if (tr[i] - tr[i - 1] != 64) begin errors++; $display("FAIL rx_symbol_len %0d: got %0d expected 64", i, tr[i] - tr[i - 1]); end
    end
    checks++; if (done_cyc != 640) begin errors++; $display("FAIL rx_done_cycle: got %0d expected 640", done_cyc); end
    checks++; if (bus_c.tx_busy !== 1'b0) begin errors++; $display("FAIL rx_busy_end: got %b expected 0", bus_c.tx_busy); end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_back_to_back();
    test_parity_stop2();
    test_reset_mid_frame();
    test_ignore_busy();
    test_default_rx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
